// File: rtl/add_sub_acc_unit.sv
// Purpose: registered WIDTH-bit add/subtract/accumulate unit with C/V/Z/N flags and optional signed saturation.
// Latency: 1 cycle from operand accept to result on S_o/flags with VALID_o=1; one result per cycle.
// Backpressure: one-deep output stage; READY_o = !VALID_o || READY_i, so a held result stalls the input side.
//
// Ports:
//   CLK_i, RSTN_i            clock, asynchronous active-low reset
//   VALID_i/READY_o          operand handshake (A_i, B_i, OP_i)
//   OP_i                     00 A+B, 01 A-B, 10 ACC+A, 11 ACC-A
//   VALID_o/READY_i          result handshake (S_o, C_o, V_o, Z_o, N_o)
module add_sub_acc_unit #(
    parameter int WIDTH = 4,
    parameter bit SAT   = 1'b0
) (
    input  logic             CLK_i,
    input  logic             RSTN_i,
    input  logic             VALID_i,
    output logic             READY_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic [1:0]       OP_i,
    output logic             VALID_o,
    input  logic             READY_i,
    output logic [WIDTH-1:0] S_o,
    output logic             C_o,
    output logic             V_o,
    output logic             Z_o,
    output logic             N_o
);

    localparam int MSB = WIDTH - 1;

    // Clamp values for signed saturation: most positive and most negative.
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_v;
    logic             r_z;
    logic             r_n;
    logic             r_vld;

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_yp;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_r;
    logic             w_c;
    logic             w_v;
    logic [WIDTH-1:0] w_res;
    logic             w_accept;

    // Accumulate ops use ACC as the left operand and A_i as the right one.
    assign w_x  = OP_i[1] ? r_acc : A_i;
    assign w_y  = OP_i[1] ? A_i   : B_i;

    // Subtraction as X + ~Y + 1, so C is the no-borrow indication.
    assign w_yp  = OP_i[0] ? ~w_y : w_y;
    assign w_sum = {1'b0, w_x} + {1'b0, w_yp} + {{WIDTH{1'b0}}, OP_i[0]};
    assign w_r   = w_sum[WIDTH-1:0];
    assign w_c   = w_sum[WIDTH];

    // Overflow: both effective operands share a sign that the raw result lost.
    assign w_v = (w_x[MSB] == w_yp[MSB]) && (w_r[MSB] != w_x[MSB]);

    // On overflow the true result has the sign of X, so clamp toward it.
    always_comb begin
        w_res = w_r;
        if (SAT && w_v) begin
            w_res = w_x[MSB] ? SAT_MIN : SAT_MAX;
        end
    end

    // Depends only on the output register and READY_i: no path from operands.
    assign READY_o  = !r_vld || READY_i;
    assign w_accept = VALID_i && READY_o;

    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            r_vld <= 1'b0;
            r_s   <= '0;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
            r_z   <= 1'b0;
            r_n   <= 1'b0;
            r_acc <= '0;
        end else if (w_accept) begin
            // Covers both an empty stage and a same-edge consume+replace.
            r_vld <= 1'b1;
            r_s   <= w_res;
            r_c   <= w_c;
            r_v   <= w_v;
            r_z   <= (w_res == '0);
            r_n   <= w_res[MSB];
            r_acc <= w_res;
        end else if (r_vld && READY_i) begin
            // Consumed with nothing new: drop valid, keep the last value visible.
            r_vld <= 1'b0;
        end
    end

    assign VALID_o = r_vld;
    assign S_o     = r_s;
    assign C_o     = r_c;
    assign V_o     = r_v;
    assign Z_o     = r_z;
    assign N_o     = r_n;

endmodule
